// File: rtl/canny_pkg.sv
// canny_pkg: shared definitions for the hysteresis threshold stage.
//   pix_class_e  - 2-bit edge class of a gradient pixel (NONE/WEAK/STRONG)
//   ht_state_e   - frame sequencing FSM states
//   DefaultHighThr / DefaultLowThr - default strong/weak thresholds
//   classify()   - maps an 8-bit gradient magnitude to its edge class
package canny_pkg;

   typedef enum logic [1:0] {
      ClsNone   = 2'd0,
      ClsWeak   = 2'd1,
      ClsStrong = 2'd2
   } pix_class_e;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFill   = 3'd1,
      StStream = 3'd2,
      StFlush  = 3'd3,
      StDone   = 3'd4
   } ht_state_e;

   localparam int unsigned DefaultHighThr = 100;
   localparam int unsigned DefaultLowThr  = 40;

   function automatic pix_class_e classify(input logic [7:0] pix,
                                           input logic [7:0] high_thr,
                                           input logic [7:0] low_thr);
      if (pix >= high_thr) begin
         return ClsStrong;
      end else if (pix >= low_thr) begin
         return ClsWeak;
      end
      return ClsNone;
   endfunction

endpackage

// File: rtl/class_line_buffer.sv
// class_line_buffer: DEPTH-deep shift register of 2-bit edge classes.
//   clk  - clock, rising edge
//   en   - shift enable; contents frozen when low
//   din  - class entering the buffer
//   dout - class that entered DEPTH enables ago (read before the shift)
// No reset: stale contents after a mid-frame abort are masked by the
// out-of-image neighbour logic in the consumer.
module class_line_buffer
   import canny_pkg::*;
#(
   parameter int unsigned DEPTH = 64
) (
   input  logic       clk,
   input  logic       en,
   input  pix_class_e din,
   output pix_class_e dout
);

   pix_class_e mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         mem_q[0] <= din;
         for (int i = 1; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_q[i-1];
         end
      end
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/hysteresis_threshold.sv
// hysteresis_threshold: single-pass hysteresis edge thresholding over a
// raster-order stream of gradient magnitudes.
//   clk      - clock, rising edge
//   reset    - synchronous active-high reset
//   enb      - global enable; low stalls everything
//   inValid  - pixelIn valid this cycle
//   pixelIn  - 8-bit gradient magnitude, raster order
//   outValid - edgeOut valid this cycle
//   edgeOut  - 0 or 255 per pixel, raster order
//   complete - high once the whole frame has been emitted, until reset
// A pixel is an edge if it is STRONG, or WEAK with a STRONG 8-neighbour.
// Output for pixel k is registered on the tick that brings in position
// k+IMG_WIDTH+1; the last IMG_WIDTH+1 outputs are drained by flush ticks.
module hysteresis_threshold
   import canny_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned IMG_HEIGHT = 64,
   parameter int unsigned HIGH_THR   = DefaultHighThr,
   parameter int unsigned LOW_THR    = DefaultLowThr
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enb,
   input  logic       inValid,
   input  logic [7:0] pixelIn,
   output logic       outValid,
   output logic [7:0] edgeOut,
   output logic       complete
);

   localparam int unsigned CW  = $clog2(IMG_WIDTH);
   localparam int unsigned RW  = $clog2(IMG_HEIGHT);
   localparam int unsigned FCW = $clog2(IMG_WIDTH + 1);

   localparam logic [CW-1:0]  ColLast   = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0]  RowLast   = RW'(IMG_HEIGHT - 1);
   localparam logic [FCW-1:0] FlushLast = FCW'(IMG_WIDTH);
   localparam logic [7:0]     HighThr   = 8'(HIGH_THR);
   localparam logic [7:0]     LowThr    = 8'(LOW_THR);

   ht_state_e state_q, state_d;

   // Input-side raster position (next pixel to accept)
   logic [CW-1:0]  col_q;
   logic [RW-1:0]  row_q;
   // Output-side raster position (centre pixel of the window)
   logic [CW-1:0]  ocol_q;
   logic [RW-1:0]  orow_q;
   logic [FCW-1:0] fcnt_q;

   // Window columns held in registers: index 0 = centre column,
   // index 1 = left column. The right column comes straight from the taps.
   pix_class_e win_top_q [2];
   pix_class_e win_mid_q [2];
   pix_class_e win_bot_q [2];

   logic       out_valid_q;
   logic [7:0] edge_q;

   logic       accept;
   logic       flush_tick;
   logic       shift;
   logic       emit;
   pix_class_e new_cls;
   pix_class_e lb1_out;
   pix_class_e lb2_out;

   logic has_top, has_bot, has_left, has_right;
   logic nbr_strong;
   logic is_edge;

   assign accept     = enb && inValid && (state_q inside {StIdle, StFill, StStream});
   assign flush_tick = enb && (state_q == StFlush);
   assign shift      = accept || flush_tick;
   assign emit       = (accept && (state_q == StStream)) || flush_tick;
   // Flush ticks feed virtual NONE pixels below the last row
   assign new_cls    = accept ? classify(pixelIn, HighThr, LowThr) : ClsNone;

   class_line_buffer #(
      .DEPTH (IMG_WIDTH)
   ) u_lb1 (
      .clk  (clk),
      .en   (shift),
      .din  (new_cls),
      .dout (lb1_out)
   );

   class_line_buffer #(
      .DEPTH (IMG_WIDTH)
   ) u_lb2 (
      .clk  (clk),
      .en   (shift),
      .din  (lb1_out),
      .dout (lb2_out)
   );

   // Mask neighbours outside the image; this also hides stale line-buffer
   // data after a mid-frame reset and prevents row-end/row-start adjacency.
   always_comb begin
      has_top   = (orow_q != '0);
      has_bot   = (orow_q != RowLast);
      has_left  = (ocol_q != '0);
      has_right = (ocol_q != ColLast);

      nbr_strong = 1'b0;
      if (has_top  && has_left  && (win_top_q[1] == ClsStrong)) nbr_strong = 1'b1;
      if (has_top               && (win_top_q[0] == ClsStrong)) nbr_strong = 1'b1;
      if (has_top  && has_right && (lb2_out      == ClsStrong)) nbr_strong = 1'b1;
      if (has_left              && (win_mid_q[1] == ClsStrong)) nbr_strong = 1'b1;
      if (has_right             && (lb1_out      == ClsStrong)) nbr_strong = 1'b1;
      if (has_bot  && has_left  && (win_bot_q[1] == ClsStrong)) nbr_strong = 1'b1;
      if (has_bot               && (win_bot_q[0] == ClsStrong)) nbr_strong = 1'b1;
      if (has_bot  && has_right && (new_cls      == ClsStrong)) nbr_strong = 1'b1;

      is_edge = (win_mid_q[0] == ClsStrong) ||
                ((win_mid_q[0] == ClsWeak) && nbr_strong);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) state_d = StFill;
         end
         StFill: begin
            // Position IMG_WIDTH is row 1, column 0
            if (accept && (row_q == RW'(1)) && (col_q == '0)) state_d = StStream;
         end
         StStream: begin
            if (accept && (row_q == RowLast) && (col_q == ColLast)) state_d = StFlush;
         end
         StFlush: begin
            if (flush_tick && (fcnt_q == FlushLast)) state_d = StDone;
         end
         StDone: begin
            state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         col_q       <= '0;
         row_q       <= '0;
         ocol_q      <= '0;
         orow_q      <= '0;
         fcnt_q      <= '0;
         out_valid_q <= 1'b0;
         edge_q      <= 8'd0;
         for (int i = 0; i < 2; i++) begin
            win_top_q[i] <= ClsNone;
            win_mid_q[i] <= ClsNone;
            win_bot_q[i] <= ClsNone;
         end
      end else begin
         state_q     <= state_d;
         out_valid_q <= emit;

         if (accept) begin
            if (col_q == ColLast) begin
               col_q <= '0;
               row_q <= (row_q == RowLast) ? '0 : row_q + RW'(1);
            end else begin
               col_q <= col_q + CW'(1);
            end
         end

         if (emit) begin
            edge_q <= is_edge ? 8'hFF : 8'h00;
            if (ocol_q == ColLast) begin
               ocol_q <= '0;
               orow_q <= (orow_q == RowLast) ? '0 : orow_q + RW'(1);
            end else begin
               ocol_q <= ocol_q + CW'(1);
            end
         end

         if (flush_tick) begin
            fcnt_q <= fcnt_q + FCW'(1);
         end

         if (shift) begin
            win_top_q[0] <= lb2_out;
            win_top_q[1] <= win_top_q[0];
            win_mid_q[0] <= lb1_out;
            win_mid_q[1] <= win_mid_q[0];
            win_bot_q[0] <= new_cls;
            win_bot_q[1] <= win_bot_q[0];
         end
      end
   end

   assign outValid = out_valid_q;
   assign edgeOut  = edge_q;
   assign complete = (state_q == StDone);

endmodule

// File: tb/tb_hysteresis_threshold.sv
// Directed testbench for hysteresis_threshold on a 4x4 frame.
module tb_hysteresis_threshold;

   logic       clk = 1'b0;
   logic       reset;
   logic       enb;
   logic       inValid;
   logic [7:0] pixelIn;
   logic       outValid;
   logic [7:0] edgeOut;
   logic       complete;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] obs [$];
   logic [7:0] pat [16];
   logic [7:0] ex  [16];

   always #5 clk = ~clk;

   hysteresis_threshold #(
      .IMG_WIDTH  (4),
      .IMG_HEIGHT (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .enb      (enb),
      .inValid  (inValid),
      .pixelIn  (pixelIn),
      .outValid (outValid),
      .edgeOut  (edgeOut),
      .complete (complete)
   );

   // Collect every emitted pixel, sampled mid-cycle
   always @(negedge clk) begin
      if (outValid === 1'b1) obs.push_back(edgeOut);
   end

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      compared++;
      assert (o === e) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string name);
      reset   = 1'b1;
      enb     = 1'b1;
      inValid = 1'b0;
      pixelIn = 8'd0;
      tick();
      tick();
      reset = 1'b0;
      check({name, "_rst_outValid"}, 32'(outValid), 32'd0);
      check({name, "_rst_edgeOut"},  32'(edgeOut),  32'd0);
      check({name, "_rst_complete"}, 32'(complete), 32'd0);
   endtask

   // Accept one pixel; outValid appears from the 6th accept onwards
   task automatic send(input string name, input logic [7:0] p, input int idx);
      enb     = 1'b1;
      inValid = 1'b1;
      pixelIn = p;
      tick();
      inValid = 1'b0;
      check($sformatf("%s_ov_after_accept%0d", name, idx), 32'(outValid),
            (idx >= 5) ? 32'd1 : 32'd0);
   endtask

   task automatic run_frame(input string name, input logic stall);
      do_reset(name);
      obs.delete();
      for (int i = 0; i < 16; i++) begin
         send(name, pat[i], i);
         if (stall && i == 7) begin
            for (int s = 0; s < 3; s++) begin
               enb     = 1'b0;
               inValid = 1'b1;
               pixelIn = 8'd0;
               tick();
               check($sformatf("%s_stall%0d_outValid", name, s), 32'(outValid), 32'd0);
               check($sformatf("%s_stall%0d_edgeOut", name, s), 32'(edgeOut), 32'(ex[2]));
            end
            enb     = 1'b1;
            inValid = 1'b0;
         end
      end
      // Flush phase: inValid high must be ignored
      inValid = 1'b1;
      for (int n = 0; n < 20 && complete !== 1'b1; n++) tick();
      inValid = 1'b0;
      check({name, "_complete"}, 32'(complete), 32'd1);
      @(negedge clk);
      #1;
      check({name, "_count"}, 32'(obs.size()), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("%s_pix%0d", name, i),
               (i < obs.size()) ? 32'(obs[i]) : 32'hDEAD, 32'(ex[i]));
      end
      tick();
      tick();
      check({name, "_complete_held"}, 32'(complete), 32'd1);
      check({name, "_done_outValid"}, 32'(outValid), 32'd0);
      check({name, "_done_count"}, 32'(obs.size()), 32'd16);
   endtask

   initial begin
      reset   = 1'b1;
      enb     = 1'b0;
      inValid = 1'b0;
      pixelIn = 8'd0;

      // All strong
      for (int i = 0; i < 16; i++) begin pat[i] = 8'd200; ex[i] = 8'd255; end
      run_frame("strong", 1'b0);

      // All weak, no strong seed
      for (int i = 0; i < 16; i++) begin pat[i] = 8'd50; ex[i] = 8'd0; end
      run_frame("weak", 1'b0);

      // Strong seed at (1,1) in a weak field
      for (int i = 0; i < 16; i++) begin
         pat[i] = 8'd50;
         ex[i]  = ((i / 4) <= 2 && (i % 4) <= 2) ? 8'd255 : 8'd0;
      end
      pat[5] = 8'd150;
      run_frame("seed11", 1'b0);

      // Strong at (1,3), weak at (2,0): not adjacent across the row wrap
      for (int i = 0; i < 16; i++) begin pat[i] = 8'd0; ex[i] = 8'd0; end
      pat[7] = 8'd150;
      pat[8] = 8'd50;
      ex[7]  = 8'd255;
      run_frame("nowrap", 1'b0);

      // Threshold boundaries: 100 strong, 99 and 40 weak, 39 none
      for (int i = 0; i < 16; i++) begin pat[i] = 8'd40; ex[i] = 8'd0; end
      pat[0] = 8'd100;
      pat[1] = 8'd39;
      pat[4] = 8'd99;
      ex[0]  = 8'd255;
      ex[4]  = 8'd255;
      ex[5]  = 8'd255;
      run_frame("thr", 1'b0);

      // Stall for 3 cycles after the 8th pixel
      for (int i = 0; i < 16; i++) begin pat[i] = 8'd200; ex[i] = 8'd255; end
      run_frame("stall", 1'b1);

      // Abort after 7 pixels, then a full strong frame
      do_reset("abort1");
      for (int i = 0; i < 7; i++) send("abort1", 8'd200, i);
      run_frame("after_abort", 1'b0);

      // Abort with strong data, then a weak frame: stale data must not leak
      do_reset("abort2");
      for (int i = 0; i < 7; i++) send("abort2", 8'd200, i);
      for (int i = 0; i < 16; i++) begin pat[i] = 8'd50; ex[i] = 8'd0; end
      run_frame("stale", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/hysteresis_threshold.md
HYSTERESIS_THRESHOLD -- requirements
Module: hysteresis_threshold

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64, pixels per row (>=3).
REQ-002 SHALL have parameter IMG_HEIGHT, default 64, rows per frame (>=3).
REQ-003 SHALL have parameter HIGH_THR, default 100, strong-edge threshold (8-bit).
REQ-004 SHALL have parameter LOW_THR, default 40, weak-edge threshold (8-bit, < HIGH_THR).
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port enb  input  1  global enable; low = full stall.
REQ-008 SHALL have port inValid  input  1  pixelIn valid this cycle.
REQ-009 SHALL have port pixelIn  input  8  gradient magnitude from the edge-detection stage, raster order.
REQ-010 SHALL have port outValid  output  1  edgeOut valid this cycle.
REQ-011 SHALL have port edgeOut  output  8  0 or 255 per pixel, raster order.
REQ-012 SHALL have port complete  output  1  frame fully emitted.

Function
REQ-013 SHALL classify each accepted pixel: STRONG if >=HIGH_THR; WEAK if >=LOW_THR and <HIGH_THR; NONE otherwise; class stored as 2 bits.
REQ-014 SHALL accept a pixel only when enb=1, inValid=1, and state is IDLE, FILL or STREAM.
REQ-015 SHALL keep column/row counters over accepted pixels; column wraps at IMG_WIDTH-1 to 0 and increments row.
REQ-016 SHALL hold a 3x3 class window from two IMG_WIDTH-deep line buffers plus the current row.
REQ-017 SHALL treat neighbours outside the image (row -1, row IMG_HEIGHT, column -1, column IMG_WIDTH) as NONE; no wrap-around between row end and next row start.
REQ-018 SHALL emit edgeOut=255 if centre is STRONG, or centre is WEAK and any of 8 neighbours is STRONG; else 0 (single pass, no iterative propagation).
REQ-019 SHALL emit output for raster pixel k one cycle after the accept (or flush tick) of raster position k+IMG_WIDTH+1.
REQ-020 SHALL emit exactly IMG_WIDTH*IMG_HEIGHT outputs per frame, one per outValid pulse, in raster order.
REQ-021 SHALL implement FSM IDLE->FILL on first accept; FILL->STREAM after IMG_WIDTH+1 accepts; STREAM->FLUSH after last pixel (IMG_WIDTH*IMG_HEIGHT accepts); FLUSH->DONE after IMG_WIDTH+1 flush ticks.
REQ-022 SHALL generate one flush tick per enb=1 cycle in FLUSH, inserting NONE class as virtual input.
REQ-023 SHALL ignore inValid in FLUSH and DONE.
REQ-024 SHALL, with enb=0, freeze all state, counters and buffers, drive outValid=0, hold edgeOut.
REQ-025 SHALL drive outValid=0 in any cycle without an accept or flush tick.
REQ-026 SHALL hold complete=1 in DONE until reset; complete=0 elsewhere.

Reset
REQ-027 SHALL on reset=1 at a clock edge set state IDLE, counters 0, outValid 0, edgeOut 0, complete 0.
REQ-028 SHALL on reset mid-frame abandon the frame; next accept is raster pixel 0; line buffer contents need not clear (masked by REQ-017).

Structure
REQ-029 SHALL place class encodings (NONE=0, WEAK=1, STRONG=2), FSM state encodings and default thresholds in shared package canny_pkg.
REQ-030 SHALL implement line buffers as sub-module class_line_buffer (2-bit wide, IMG_WIDTH deep, shift-on-enable), instantiated twice.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, defaults otherwise)
REQ-031 SHALL test: 16 pixels of 200, enb=1 -> 16 outputs of 255, first outValid one cycle after 6th accept, complete=1 after 16th output.
REQ-032 SHALL test: 16 pixels of 50 -> 16 outputs of 0.
REQ-033 SHALL test: 150 at (1,1), 50 elsewhere -> 255 at rows 0-2 cols 0-2, 0 at the other 7 pixels.
REQ-034 SHALL test: 150 at (1,3), 50 at (2,0), 0 elsewhere -> (1,3)=255, (2,0)=0 (no row-wrap adjacency).
REQ-035 SHALL test: enb=0 for 3 cycles after 8th pixel -> no outValid, edgeOut held, still exactly 16 outputs matching REQ-031.
REQ-036 SHALL test: reset after 7 pixels, then full 200 frame -> identical to REQ-031.
